// File: rtl/gs_if_fetch.sv
// Instruction-fetch stage: issues in-order word fetches to instruction memory,
// tags each request with its PC and buffers the returned words in a small
// prefetch FIFO that decode drains through a valid/ready handshake.
//
// Handshakes (valid/ready): the decode side sees if_fetch_valid_o, which is
// held with a stable head until it is taken. A transfer happens on a rising
// edge where if_fetch_valid_o && id_ready_i && !halt_if_i. On the memory side
// a request transfers on a rising edge where imem_req_o && imem_gnt_i, and
// imem_req_o may be withdrawn before it is granted.
module gs_if_fetch #(
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_fetch_i,
    input  logic [3:0]  pc_mux_sel_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] jump_target_i,
    input  logic        flush_if_i,
    input  logic        halt_if_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        id_ready_i,
    output logic        if_fetch_valid_o,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o,
    output logic        dbg_state_o
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_N = CW'(FIFO_DEPTH);
    localparam logic [3:0] PC_BOOT   = 4'd0;
    localparam logic [3:0] PC_BRANCH = 4'd2;
    localparam logic [3:0] PC_JUMP   = 4'd3;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_eff;
    logic [CW:0]   occupancy;
    logic [31:0]   tag_q  [FIFO_DEPTH];
    logic [31:0]   tag_d  [FIFO_DEPTH];
    logic [31:0]   bpc_q  [FIFO_DEPTH];
    logic [31:0]   bpc_d  [FIFO_DEPTH];
    logic [31:0]   bins_q [FIFO_DEPTH];
    logic [31:0]   bins_d [FIFO_DEPTH];
    logic          redirect, pop, push, accept, dropping;
    logic [31:0]   target;

    // Control decode. The issue bound counts the head as already gone when it
    // is popped this cycle, so a 1-cycle memory sustains one fetch per cycle.
    always_comb begin
        redirect  = flush_if_i && (pc_mux_sel_i == PC_BRANCH || pc_mux_sel_i == PC_JUMP);
        target    = (pc_mux_sel_i == PC_JUMP) ? jump_target_i : branch_target_i;
        pop       = (cnt_q != '0) && id_ready_i && !halt_if_i;
        cnt_eff   = cnt_q - CW'(pop);
        occupancy = {1'b0, cnt_eff} + {1'b0, out_q};
        dropping  = imem_rvalid_i && (drop_q != '0);
        push      = imem_rvalid_i && !dropping && !flush_if_i;
    end

    // FSM next state and request generation; flush and halt suppress issue.
    always_comb begin
        state_d    = state_q;
        imem_req_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (instr_fetch_i) state_d = S_RUN;
            end
            S_RUN: begin
                if (!halt_if_i && !flush_if_i && (occupancy < DEPTH_W)) imem_req_o = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign accept           = imem_req_o && imem_gnt_i;
    assign imem_addr_o      = pc_q;
    assign if_fetch_valid_o = (cnt_q != '0);
    assign if_pc_o          = if_fetch_valid_o ? bpc_q[0] : 32'd0;
    assign if_instr_o       = if_fetch_valid_o ? bins_q[0] : 32'd0;
    assign dbg_state_o      = (state_q == S_RUN);

    // Next-state for fetch PC, in-flight tags, drop counter and prefetch FIFO.
    always_comb begin
        pc_d   = pc_q;
        out_d  = out_q + CW'(accept) - CW'(imem_rvalid_i);
        drop_d = drop_q;
        cnt_d  = cnt_q;
        tag_d  = tag_q;
        bpc_d  = bpc_q;
        bins_d = bins_q;

        if (redirect) begin
            pc_d = {target[31:2], 2'b00};
        end else if (state_q == S_IDLE && pc_mux_sel_i == PC_BOOT) begin
            pc_d = BOOT_ADDR;
        end else if (accept) begin
            pc_d = pc_q + 32'd4;
        end

        // Tags are kept oldest-first; a response retires tag slot 0.
        if (imem_rvalid_i) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) tag_d[i] = tag_q[i + 1];
        end
        if (accept) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (CW'(i) == out_q - CW'(imem_rvalid_i)) tag_d[i] = pc_q;
            end
        end

        // Every response still owed after a flush belongs to discarded work.
        if (flush_if_i) begin
            drop_d = out_q - CW'(imem_rvalid_i);
        end else if (dropping) begin
            drop_d = drop_q - CW'(1);
        end

        if (flush_if_i) begin
            cnt_d = '0;
        end else begin
            if (pop) begin
                for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                    bpc_d[i]  = bpc_q[i + 1];
                    bins_d[i] = bins_q[i + 1];
                end
            end
            cnt_d = cnt_eff;
            if (push) begin
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    if (CW'(i) == cnt_eff) begin
                        bpc_d[i]  = tag_q[0];
                        bins_d[i] = imem_rdata_i;
                    end
                end
                cnt_d = cnt_eff + CW'(1);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Datapath registers; reset drops all buffered and in-flight work.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q   <= BOOT_ADDR;
            out_q  <= '0;
            drop_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                tag_q[i]  <= 32'd0;
                bpc_q[i]  <= 32'd0;
                bins_q[i] <= 32'd0;
            end
        end else begin
            pc_q   <= pc_d;
            out_q  <= out_d;
            drop_q <= drop_d;
            cnt_q  <= cnt_d;
            tag_q  <= tag_d;
            bpc_q  <= bpc_d;
            bins_q <= bins_d;
        end
    end

    outstanding_bound_a: assert property (@(posedge clk) disable iff (!rst) out_q <= DEPTH_N);

endmodule

// File: tb/tb_gs_if_fetch.sv
// Bench for gs_if_fetch: random-latency memory, queue-based reference model
// of the fetch stream, directed phases for boot, backpressure, redirects,
// halt, address wrap and asynchronous reset.
module tb_gs_if_fetch;
  localparam logic [31:0] BOOT = 32'h0000_0100;
  localparam int DEPTH = 2;
  localparam logic [3:0] PC_BOOT = 4'd0, PC_NORMAL = 4'd1, PC_BRANCH = 4'd2, PC_JUMP = 4'd3;

  logic clk, rst;
  logic instr_fetch_i, flush_if_i, halt_if_i, id_ready_i;
  logic [3:0] pc_mux_sel_i;
  logic [31:0] branch_target_i, jump_target_i;
  logic imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic if_fetch_valid_o;
  logic [31:0] if_instr_o, if_pc_o;
  logic dbg_state_o;

  gs_if_fetch #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .instr_fetch_i(instr_fetch_i), .pc_mux_sel_i(pc_mux_sel_i),
    .branch_target_i(branch_target_i), .jump_target_i(jump_target_i),
    .flush_if_i(flush_if_i), .halt_if_i(halt_if_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .id_ready_i(id_ready_i), .if_fetch_valid_o(if_fetch_valid_o),
    .if_instr_o(if_instr_o), .if_pc_o(if_pc_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // memory model: actual granted addresses and their response cycles
  logic [31:0] mem_addr_q[$];
  int mem_due_q[$];
  // reference model: delivered-but-unconsumed PCs, in-flight PCs, fetch PC
  logic [31:0] exp_q[$];
  logic [31:0] fly_q[$];
  logic [31:0] m_pc;
  bit m_run;
  int m_drop;
  // logs for directed checks
  logic [31:0] gnt_log[$], pop_log[$];
  int gnt_cyc_log[$], pop_cyc_log[$];
  int cyc = 0;
  int gnt_pct = 100;
  int lat_lo = 1, lat_hi = 1;
  logic last_rvalid;

  task automatic model_reset();
    mem_addr_q.delete();
    mem_due_q.delete();
    exp_q.delete();
    fly_q.delete();
    m_pc = BOOT;
    m_run = 0;
    m_drop = 0;
  endtask

  // driver: one clock cycle with the given controls; memory and model advance
  task automatic drive_cycle(input logic fl, input logic [3:0] sel, input logic [31:0] tgt,
                             input logic hlt, input logic rdy, input logic fch);
    int exp_valid, pop_now, exp_req, due;
    logic [31:0] a;
    instr_fetch_i = fch;
    pc_mux_sel_i = sel;
    flush_if_i = fl;
    halt_if_i = hlt;
    id_ready_i = rdy;
    branch_target_i = (sel == PC_BRANCH) ? tgt : $urandom();
    jump_target_i = (sel == PC_JUMP) ? tgt : $urandom();
    imem_gnt_i = ($urandom_range(99, 0) < gnt_pct);
    if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i = mem_word(mem_addr_q[0]);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i = $urandom();
    end
    last_rvalid = imem_rvalid_i;
    @(negedge clk);
    exp_valid = (exp_q.size() > 0) ? 1 : 0;
    check("valid", if_fetch_valid_o, exp_valid);
    check("head_pc", if_pc_o, exp_valid ? exp_q[0] : 32'd0);
    check("head_instr", if_instr_o, exp_valid ? mem_word(exp_q[0]) : 32'd0);
    pop_now = (exp_valid != 0 && rdy && !hlt) ? 1 : 0;
    exp_req = (m_run && !hlt && !fl && (exp_q.size() - pop_now + fly_q.size() < DEPTH)) ? 1 : 0;
    check("req", imem_req_o, exp_req);
    if (exp_req != 0) check("addr", imem_addr_o, m_pc);
    // memory side
    if (imem_rvalid_i) begin
      mem_addr_q.pop_front();
      void'(mem_due_q.pop_front());
    end
    if (imem_req_o && imem_gnt_i) begin
      due = cyc + $urandom_range(lat_hi, lat_lo);
      if (mem_due_q.size() > 0 && due <= mem_due_q[$]) due = mem_due_q[$] + 1;
      mem_addr_q.push_back(imem_addr_o);
      mem_due_q.push_back(due);
      gnt_log.push_back(imem_addr_o);
      gnt_cyc_log.push_back(cyc);
    end
    // reference model
    if (pop_now != 0) begin
      pop_log.push_back(exp_q[0]);
      pop_cyc_log.push_back(cyc);
      exp_q.pop_front();
    end
    if (imem_rvalid_i && fly_q.size() > 0) begin
      a = fly_q.pop_front();
      if (m_drop > 0) m_drop--;
      else if (!fl) exp_q.push_back(a);
    end
    if (fl) begin
      exp_q.delete();
      m_drop = fly_q.size();
    end
    if (exp_req != 0 && imem_gnt_i) begin
      fly_q.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
    if (fl && (sel == PC_BRANCH || sel == PC_JUMP)) m_pc = {tgt[31:2], 2'b00};
    else if (!m_run && sel == PC_BOOT) m_pc = BOOT;
    if (!m_run && fch) m_run = 1;
    check("outstanding_bound", (mem_addr_q.size() <= DEPTH), 1'b1);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    instr_fetch_i = 0; flush_if_i = 0; halt_if_i = 0; id_ready_i = 0;
    pc_mux_sel_i = PC_BOOT; branch_target_i = 0; jump_target_i = 0;
    imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
  endtask

  task automatic norm(input int n, input logic rdy);
    for (int k = 0; k < n; k++) drive_cycle(1'b0, PC_NORMAL, 32'd0, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    int n_start, g0, p0, r_cyc, found;
    logic [31:0] saved_pc;
    bit ok;
    idle_inputs();
    model_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", imem_req_o, 1'b0);
    check("rst_addr", imem_addr_o, BOOT);
    check("rst_valid", if_fetch_valid_o, 1'b0);
    check("rst_instr", if_instr_o, 32'd0);
    check("rst_pc", if_pc_o, 32'd0);
    check("rst_state", dbg_state_o, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // boot: always-grant, 1-cycle memory, decode always ready
    gnt_pct = 100; lat_lo = 1; lat_hi = 1;
    drive_cycle(1'b0, PC_BOOT, 32'd0, 1'b0, 1'b1, 1'b0);
    n_start = cyc;
    drive_cycle(1'b0, PC_BOOT, 32'd0, 1'b0, 1'b1, 1'b1);
    norm(8, 1'b1);
    check("boot_gnt_cnt", (gnt_log.size() >= 3), 1'b1);
    check("boot_pop_cnt", (pop_log.size() >= 3), 1'b1);
    if (gnt_log.size() >= 3 && pop_log.size() >= 3) begin
      for (int k = 0; k < 3; k++) begin
        check("boot_req_addr", gnt_log[k], BOOT + 32'(4 * k));
        check("boot_req_cycle", gnt_cyc_log[k], n_start + 1 + k);
        check("boot_pop_pc", pop_log[k], BOOT + 32'(4 * k));
        check("boot_pop_cycle", pop_cyc_log[k], n_start + 3 + k);
      end
    end

    // backpressure then in-order drain
    lat_lo = 1; lat_hi = 2;
    p0 = pop_log.size();
    norm(8, 1'b0);
    check("bp_full_valid", if_fetch_valid_o, 1'b1);
    check("bp_no_req", imem_req_o, 1'b0);
    norm(8, 1'b1);
    ok = 1;
    for (int k = p0 + 1; k < pop_log.size(); k++) if (pop_log[k] != pop_log[k - 1] + 32'd4) ok = 0;
    check("bp_order", ok, 1'b1);

    // branch redirect with two outstanding fetches
    lat_lo = 3; lat_hi = 3;
    found = 0;
    for (int k = 0; k < 50 && found == 0; k++) begin
      if (fly_q.size() == 2) found = 1;
      else drive_cycle(1'b0, PC_NORMAL, 32'd0, 1'b0, 1'b1, 1'b0);
    end
    check("wait_two_outstanding", found, 1);
    r_cyc = cyc; g0 = gnt_log.size(); p0 = pop_log.size();
    drive_cycle(1'b1, PC_BRANCH, 32'h0000_2002, 1'b0, 1'b1, 1'b0);
    check("redir_valid_r1", if_fetch_valid_o, 1'b0);
    norm(10, 1'b1);
    check("redir_gnt_addr", (gnt_log.size() > g0) ? gnt_log[g0] : 32'hDEAD_BEEF, 32'h0000_2000);
    check("redir_gnt_cycle", (gnt_cyc_log.size() > g0) ? gnt_cyc_log[g0] : -1, r_cyc + 1);
    check("redir_first_pop", (pop_log.size() > p0) ? pop_log[p0] : 32'hDEAD_BEEF, 32'h0000_2000);
    check("redir_pop_latency", (pop_cyc_log.size() > p0) && (pop_cyc_log[p0] >= r_cyc + 3), 1'b1);

    // redirect coincident with a response
    lat_lo = 1; lat_hi = 2;
    found = 0;
    for (int k = 0; k < 50 && found == 0; k++) begin
      if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) found = 1;
      else drive_cycle(1'b0, PC_NORMAL, 32'd0, 1'b0, 1'b1, 1'b0);
    end
    check("wait_coincident", found, 1);
    p0 = pop_log.size();
    drive_cycle(1'b1, PC_JUMP, 32'h0000_3000, 1'b0, 1'b1, 1'b0);
    check("coincident_rvalid", last_rvalid, 1'b1);
    norm(8, 1'b1);
    check("coincident_first_pop", (pop_log.size() > p0) ? pop_log[p0] : 32'hDEAD_BEEF, 32'h0000_3000);

    // halt with a valid head and a response in flight
    lat_lo = 2; lat_hi = 2;
    found = 0;
    for (int k = 0; k < 50 && found == 0; k++) begin
      if (exp_q.size() > 0 && fly_q.size() > 0) found = 1;
      else drive_cycle(1'b0, PC_NORMAL, 32'd0, 1'b0, 1'b1, 1'b0);
    end
    check("wait_halt_setup", found, 1);
    saved_pc = if_pc_o;
    for (int k = 0; k < 3; k++) drive_cycle(1'b0, PC_NORMAL, 32'd0, 1'b1, 1'b1, 1'b0);
    check("halt_head_pc", if_pc_o, saved_pc);
    check("halt_head_instr", if_instr_o, mem_word(saved_pc));
    norm(6, 1'b1);

    // jump to the top word: fetch address wraps to zero
    lat_lo = 1; lat_hi = 1;
    g0 = gnt_log.size();
    drive_cycle(1'b1, PC_JUMP, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0);
    norm(6, 1'b1);
    check("wrap_addr0", (gnt_log.size() > g0) ? gnt_log[g0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    check("wrap_addr1", (gnt_log.size() > g0 + 1) ? gnt_log[g0 + 1] : 32'hDEAD_BEEF, 32'h0000_0000);

    // randomized traffic
    gnt_pct = 70; lat_lo = 1; lat_hi = 3;
    for (int k = 0; k < 400; k++) begin
      logic fl, hl, rd;
      logic [3:0] sel;
      fl = ($urandom_range(99, 0) < 5);
      sel = fl ? 4'($urandom_range(3, 1)) : PC_NORMAL;
      hl = ($urandom_range(99, 0) < 15);
      rd = ($urandom_range(99, 0) < 70);
      drive_cycle(fl, sel, $urandom(), hl, rd, 1'b0);
    end

    // asynchronous reset in the middle of fetching
    gnt_pct = 100; lat_lo = 1; lat_hi = 2;
    norm(5, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_req", imem_req_o, 1'b0);
    check("arst_addr", imem_addr_o, BOOT);
    check("arst_valid", if_fetch_valid_o, 1'b0);
    check("arst_instr", if_instr_o, 32'd0);
    check("arst_pc", if_pc_o, 32'd0);
    check("arst_state", dbg_state_o, 1'b0);
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc++;
    g0 = gnt_log.size();
    drive_cycle(1'b0, PC_BOOT, 32'd0, 1'b0, 1'b1, 1'b0);
    drive_cycle(1'b0, PC_BOOT, 32'd0, 1'b0, 1'b1, 1'b1);
    norm(6, 1'b1);
    check("restart_addr", (gnt_log.size() > g0) ? gnt_log[g0] : 32'hDEAD_BEEF, BOOT);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
